// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
// trap_controller : trap/interrupt sequencer beside the ID stage
// Revision: 1.0
// ============================================================================
module trap_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_irq,
  input  logic            MEIE,
  input  logic            MRET,
  input  logic            WFI,
  input  logic [PC_W-1:0] mtvec_pc,
  input  logic [PC_W-1:0] mepc_pc,
  input  logic            stall,
  output logic            interrupt,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            halt,
  output logic            in_handler,
  output logic            irq_pending
);

  localparam logic [2:0] c_ST_RUN     = 3'd0;
  localparam logic [2:0] c_ST_SLEEP   = 3'd1;
  localparam logic [2:0] c_ST_ENTER   = 3'd2;
  localparam logic [2:0] c_ST_HANDLER = 3'd3;
  localparam logic [2:0] c_ST_RETURN  = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic                   r_in_handler;
  logic                   w_irq;

  // ext_irq is asynchronous: the synchronizer runs even while the core stalls
  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= ext_irq;
      end
    end else begin : g_sync_chain
      always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], ext_irq};
      end
    end
  endgenerate

  assign w_irq = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (w_irq && MEIE) w_state_nxt = c_ST_ENTER;
        else if (MRET)     w_state_nxt = c_ST_RETURN;
        else if (WFI)      w_state_nxt = c_ST_SLEEP;
      end
      c_ST_SLEEP: begin
        if (w_irq) w_state_nxt = MEIE ? c_ST_ENTER : c_ST_RUN;
      end
      c_ST_ENTER:   w_state_nxt = c_ST_HANDLER;
      c_ST_HANDLER: begin
        if (MRET) w_state_nxt = c_ST_RETURN;
      end
      c_ST_RETURN:  w_state_nxt = c_ST_RUN;
      default:      w_state_nxt = c_ST_RUN;
    endcase
  end

  // in_handler is tracked separately so a software MRET from RUN never sets it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_ST_RUN;
      r_in_handler <= 1'b0;
    end else if (!stall) begin
      r_state <= w_state_nxt;
      if (r_state == c_ST_ENTER)       r_in_handler <= 1'b1;
      else if (r_state == c_ST_RETURN) r_in_handler <= 1'b0;
    end
  end

  assign interrupt      = (r_state == c_ST_ENTER) && !stall;
  assign redirect_valid = (r_state == c_ST_ENTER) || (r_state == c_ST_RETURN);
  assign redirect_pc    = (r_state == c_ST_ENTER)  ? mtvec_pc :
                          (r_state == c_ST_RETURN) ? mepc_pc  : '0;
  assign flush          = redirect_valid;
  assign halt           = (r_state == c_ST_SLEEP);
  assign in_handler     = r_in_handler;
  assign irq_pending    = w_irq;

endmodule
`default_nettype wire

// File: tb/tb_trap_controller.sv
`default_nettype none
// ============================================================================
// tb_trap_controller : directed vector bench for trap_controller
// Revision: 1.0
// ============================================================================
module tb_trap_controller;

  localparam logic [31:0] c_MTVEC = 32'h0001_0000;
  localparam logic [31:0] c_MEPC  = 32'h0000_0124;

  logic        clk = 1'b0;
  logic        rst, ext_irq, MEIE, MRET, WFI, stall;
  logic [31:0] mtvec_pc, mepc_pc, redirect_pc;
  logic        interrupt, redirect_valid, flush, halt, in_handler, irq_pending;

  int n_vec = 0;
  int n_bad = 0;

  // in  = {rst, ext_irq, MEIE, MRET, WFI, stall}
  // flg = {interrupt, redirect_valid, flush, halt, in_handler, irq_pending}
  typedef struct {
    logic [5:0]  in;
    logic [5:0]  flg;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  trap_controller #(.SYNC_STAGES(2), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .MEIE(MEIE), .MRET(MRET), .WFI(WFI),
    .mtvec_pc(mtvec_pc), .mepc_pc(mepc_pc), .stall(stall),
    .interrupt(interrupt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .halt(halt), .in_handler(in_handler), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic add(input logic [5:0] i, input logic [5:0] f, input logic [31:0] pc);
    vec_t v;
    v.in = i; v.flg = f; v.pc = pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    {rst, ext_irq, MEIE, MRET, WFI, stall} = 6'b100000;
    step();
    rst = 1'b0;
  endtask

  int pulses;
  int cnt;

  initial begin
    mtvec_pc = c_MTVEC;
    mepc_pc  = c_MEPC;
    {rst, ext_irq, MEIE, MRET, WFI, stall} = 6'b110000;

    // reset with irq high, then sync latency and a basic trap/return
    add(6'b110000, 6'b000000, 32'h0);
    add(6'b110000, 6'b000000, 32'h0);
    add(6'b010000, 6'b000000, 32'h0);
    add(6'b010000, 6'b000001, 32'h0);
    add(6'b010000, 6'b000001, 32'h0);
    add(6'b000000, 6'b000001, 32'h0);
    add(6'b000000, 6'b000000, 32'h0);
    add(6'b011000, 6'b000000, 32'h0);
    add(6'b011000, 6'b000001, 32'h0);
    add(6'b011000, 6'b111001, c_MTVEC);
    add(6'b001000, 6'b000011, 32'h0);
    add(6'b001000, 6'b000010, 32'h0);
    add(6'b001010, 6'b000010, 32'h0);
    add(6'b001100, 6'b011010, c_MEPC);
    add(6'b001000, 6'b000000, 32'h0);
    // WFI sleep, wake without trap
    add(6'b000010, 6'b000100, 32'h0);
    add(6'b000000, 6'b000100, 32'h0);
    add(6'b000001, 6'b000100, 32'h0);
    add(6'b010000, 6'b000100, 32'h0);
    add(6'b010000, 6'b000101, 32'h0);
    add(6'b010000, 6'b000001, 32'h0);
    add(6'b000000, 6'b000001, 32'h0);
    add(6'b000000, 6'b000000, 32'h0);
    // software MRET outside a handler, stalled RETURN
    add(6'b000100, 6'b011000, c_MEPC);
    add(6'b000001, 6'b011000, c_MEPC);
    add(6'b000000, 6'b000000, 32'h0);
    // priorities in RUN, stalled ENTER
    add(6'b011100, 6'b011000, c_MEPC);
    add(6'b011110, 6'b000001, 32'h0);
    add(6'b011110, 6'b111001, c_MTVEC);
    add(6'b000001, 6'b011001, c_MTVEC);
    add(6'b000000, 6'b000010, 32'h0);
    add(6'b000100, 6'b011010, c_MEPC);
    add(6'b000000, 6'b000000, 32'h0);
    // reset mid-trap
    add(6'b011000, 6'b000000, 32'h0);
    add(6'b011000, 6'b000001, 32'h0);
    add(6'b011000, 6'b111001, c_MTVEC);
    add(6'b111000, 6'b000000, 32'h0);
    add(6'b000000, 6'b000000, 32'h0);

    foreach (vecs[k]) begin
      {rst, ext_irq, MEIE, MRET, WFI, stall} = vecs[k].in;
      step();
      chk($sformatf("vec%0d", k),
          {26'h0, interrupt, redirect_valid, flush, halt, in_handler, irq_pending, redirect_pc},
          {26'h0, vecs[k].flg, vecs[k].pc});
    end

    // WFI: halt held 20 cycles, wake with MEIE=0 gives no trap
    do_reset();
    WFI = 1'b1;
    step();
    WFI = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (halt) cnt++;
      step();
    end
    chk("sleep_halt_cycles", 64'(cnt), 64'd20);
    ext_irq = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10 && halt; i++) begin
      step();
      if (interrupt) pulses++;
    end
    chk("wake_no_trap", {61'h0, halt, redirect_valid, in_handler}, 64'h0);
    chk("wake_no_pulse", 64'(pulses), 64'd0);
    ext_irq = 1'b0;
    repeat (3) step();

    // WFI wake with MEIE=1 traps
    MEIE = 1'b1;
    WFI  = 1'b1;
    step();
    WFI = 1'b0;
    chk("sleep2_halt", {63'h0, halt}, 64'h1);
    ext_irq = 1'b1;
    for (int i = 0; i < 10 && !redirect_valid; i++) step();
    chk("sleep_wake_enter", {interrupt, halt, flush, 29'h0, redirect_pc},
        {1'b1, 1'b0, 1'b1, 29'h0, c_MTVEC});

    // reset mid-sleep
    do_reset();
    WFI = 1'b1;
    step();
    WFI = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_mid_sleep", {62'h0, halt, irq_pending}, 64'h0);

    // stall for 4 cycles on ENTER arrival: one effective pulse
    MEIE    = 1'b1;
    ext_irq = 1'b1;
    for (int i = 0; i < 10 && !redirect_valid; i++) step();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      stall = (i < 4);
      #1;
      if (interrupt) pulses++;
      chk($sformatf("enter_stall_c%0d", i), {30'h0, redirect_valid, interrupt, redirect_pc},
          {30'h0, 1'b1, (i == 4), c_MTVEC});
      step();
    end
    stall = 1'b0;
    chk("enter_pulses", 64'(pulses), 64'd1);
    chk("handler_after_enter", {62'h0, redirect_valid, in_handler}, 64'h1);

    // MRET with irq still high: RETURN, one RUN cycle, then ENTER
    MRET = 1'b1;
    step();
    MRET = 1'b0;
    chk("prio_return", {29'h0, interrupt, redirect_valid, in_handler, redirect_pc},
        {29'h0, 1'b0, 1'b1, 1'b1, c_MEPC});
    step();
    chk("prio_run", {61'h0, redirect_valid, in_handler, interrupt}, 64'h0);
    step();
    chk("prio_reenter", {30'h0, interrupt, redirect_valid, redirect_pc},
        {30'h0, 1'b1, 1'b1, c_MTVEC});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
